spi_accel_responder: RTL and testbench
======================================

SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

Interface
REQ-001 SHALL have parameter DEVID_AD, default 8'hAD, value returned at register 0x00.
REQ-002 SHALL have parameter DEVID_MST, default 8'h1D, value returned at register 0x01.
REQ-003 SHALL have parameter PARTID, default 8'hF2, value returned at register 0x02.
REQ-004 SHALL have port i_clk  input  1  system clock, 100 MHz.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low; one clock, no other clock domains.
REQ-006 SHALL have port ACL_SCLK  input  1  SPI clock from the master, mode 0, asynchronous to i_clk.
REQ-007 SHALL have port ACL_CSN  input  1  SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port ACL_MOSI  input  1  SPI data from the master, asynchronous.
REQ-009 SHALL have port i_accel_x / i_accel_y / i_accel_z  input  12 each  signed two's-complement acceleration samples.
REQ-010 SHALL have port i_sample_valid  input  1  one-cycle strobe that qualifies a new x/y/z sample.
REQ-011 SHALL have port ACL_MISO  output  1  registered SPI data to the master.
REQ-012 SHALL have port o_power_ctl  output  8  current POWER_CTL register value.
REQ-013 SHALL have port o_busy  output  1  high while a transaction is active (synchronized CSN low).
REQ-014 SHALL have port o_txn_done  output  1  one-cycle pulse when CSN deasserts after at least one complete byte.

Function
REQ-015 SHALL synchronize SCLK, CSN and MOSI through two flops, then detect SCLK rise/fall edges from the synchronized signal; SCLK half-period >= 8 i_clk cycles is supported.
REQ-016 SHALL sample MOSI on each detected SCLK rising edge, MSB first, and count bits modulo 8 with a byte counter saturating at 3.
REQ-017 SHALL implement FSM IDLE -> CMD -> ADDR -> DATA -> IDLE: CSN fall enters CMD; 8th bit enters ADDR; 8th bit enters DATA; CSN rise returns to IDLE from any state.
REQ-018 SHALL decode command 0x0A as write and 0x0B as read; any other command ignores all following bytes, drives MISO 0 and updates no register.
REQ-019 SHALL map registers: 0x00 DEVID_AD, 0x01 DEVID_MST, 0x02 PARTID, 0x0B STATUS (bit0 = DATA_READY, others 0), 0x0E..0x13 X/Y/Z low/high, 0x2D POWER_CTL (R/W); all other addresses read 0x00 and ignore writes.
REQ-020 SHALL form data bytes as L = sample[7:0] and H = {4{sample[11]}, sample[11:8]}.
REQ-021 SHALL report measurement data only when POWER_CTL[1:0] == 2'b10; otherwise 0x0E..0x13 read 0x00 and DATA_READY reads 0.
REQ-022 SHALL latch x/y/z into a holding register on i_sample_valid and copy the holding register to a snapshot on CSN fall; simultaneous strobe and CSN fall snapshots the new sample; reads use only the snapshot (no tearing within a burst).
REQ-023 SHALL set DATA_READY on i_sample_valid while measuring and clear it at CSN rise if the transaction read any byte of 0x0E..0x13; simultaneous set and clear leaves it set.
REQ-024 SHALL, for a read, load the addressed byte into the TX shifter on the first SCLK falling edge after the ADDR byte completes, shift it out MSB first on subsequent falling edges, and reload the next byte every 8 bits.
REQ-025 SHALL auto-increment the address after every data byte, wrapping 0x3F -> 0x00 on a 6-bit address (address bits [7:6] ignored).
REQ-026 SHALL commit a write byte only on its 8th rising edge; a partial byte at CSN rise is discarded, previously committed bytes remain.
REQ-027 SHALL drive ACL_MISO 0 while CSN is high and during CMD/ADDR; MISO changes within 3 i_clk cycles of the SCLK falling pin edge.
REQ-028 SHALL assert o_busy from synchronized CSN fall to synchronized CSN rise, and pulse o_txn_done in the cycle of CSN rise only if byte count >= 1.

Reset
REQ-029 SHALL, on i_rst_n low, immediately clear ACL_MISO, o_busy, o_txn_done, POWER_CTL (0x00), DATA_READY, the holding register, the snapshot, the shifters and the counters, and force the FSM to IDLE.
REQ-030 SHALL, after reset release, ignore any transaction already in progress until the next CSN fall.

Verification
REQ-031 SHALL cover: reset, read 0x0B,0x00 then 3 bytes -> MISO 0xAD, 0x1D, 0xF2.
REQ-032 SHALL cover: write 0x0A,0x2D,0x02 -> o_power_ctl = 0x02, o_txn_done pulses once; readback of 0x2D = 0x02.
REQ-033 SHALL cover: measuring, sample x=12'h800, y=12'h123, z=12'h7FF, read burst from 0x0E -> 0x00,0xF8,0x23,0x01,0xFF,0x07; DATA_READY then reads 0.
REQ-034 SHALL cover: new sample strobed mid-burst -> remaining bytes still from the old snapshot; the next transaction returns the new values.
REQ-035 SHALL cover: CSN rise after 4 bits of a write data byte to 0x2D -> POWER_CTL unchanged; POWER_CTL=0x00 -> 0x0E reads 0x00.
REQ-036 SHALL cover: i_rst_n low mid-read -> ACL_MISO 0 and o_power_ctl 0x00 in the same cycle; the next transaction after release operates normally.

Source files
------------

// File: rtl/spi_accel_responder.sv
// SPI mode-0 register responder for a 3-axis accelerometer. All SPI pins are
// oversampled in the i_clk domain. There is a single register file with an
// x/y/z sample snapshot taken at chip-select fall.
module spi_accel_responder #(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        ACL_SCLK,
  input  logic        ACL_CSN,
  input  logic        ACL_MOSI,
  input  logic [11:0] i_accel_x,
  input  logic [11:0] i_accel_y,
  input  logic [11:0] i_accel_z,
  input  logic        i_sample_valid,
  output logic        ACL_MISO,
  output logic [7:0]  o_power_ctl,
  output logic        o_busy,
  output logic        o_txn_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_ADDR = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;
  localparam logic [5:0] ADDR_MEAS_LO   = 6'h0E;
  localparam logic [5:0] ADDR_MEAS_HI   = 6'h13;

  function automatic logic [7:0] lo_byte(input logic [11:0] s);
    return s[7:0];
  endfunction

  function automatic logic [7:0] hi_byte(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  logic        sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic        csn_meta_r, csn_sync_r, csn_prev_r;
  logic        mosi_meta_r, mosi_sync_r;
  logic [1:0]  state_r;
  logic [2:0]  bit_cnt_r;
  logic [1:0]  byte_cnt_r;
  logic [7:0]  rx_shift_r;
  logic [7:0]  cmd_r;
  logic [5:0]  addr_r;
  logic [6:0]  tx_shift_r;
  logic [2:0]  tx_cnt_r;
  logic        miso_r;
  logic [7:0]  power_ctl_r;
  logic        data_ready_r;
  logic        cur_meas_r;
  logic        meas_read_r;
  logic [11:0] hold_x_r, hold_y_r, hold_z_r;
  logic [11:0] snap_x_r, snap_y_r, snap_z_r;
  logic        busy_r;
  logic        txn_done_r;

  logic        sclk_rise_s, sclk_fall_s, csn_rise_s, csn_fall_s;
  logic [7:0]  rx_byte_s;
  logic        data_byte_end_s;
  logic        wr_commit_s;
  logic        tx_load_s;
  logic        measuring_s;
  logic        is_meas_addr_s;
  logic [7:0]  rd_data_s;

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign csn_fall_s  = ~csn_sync_r & csn_prev_r;
  assign csn_rise_s  = csn_sync_r & ~csn_prev_r;
  assign rx_byte_s   = {rx_shift_r[6:0], mosi_sync_r};
  assign measuring_s = (power_ctl_r[1:0] == 2'b10);
  assign is_meas_addr_s = (addr_r >= ADDR_MEAS_LO) && (addr_r <= ADDR_MEAS_HI);

  // CSN edges take priority over any SCLK edge seen in the same cycle.
  assign data_byte_end_s = sclk_rise_s && !csn_rise_s && !csn_fall_s &&
                           (state_r == ST_DATA) && (bit_cnt_r == 3'd7);
  assign wr_commit_s = data_byte_end_s && (cmd_r == CMD_WRITE) &&
                       (addr_r == ADDR_POWER_CTL);
  assign tx_load_s   = sclk_fall_s && !csn_rise_s && !csn_fall_s &&
                       (state_r == ST_DATA) && (cmd_r == CMD_READ) &&
                       (tx_cnt_r == 3'd0);

  // Register read mux; measurement bytes come only from the snapshot.
  always_comb begin
    rd_data_s = 8'h00;
    case (addr_r)
      6'h00:   rd_data_s = DEVID_AD;
      6'h01:   rd_data_s = DEVID_MST;
      6'h02:   rd_data_s = PARTID;
      6'h0B:   rd_data_s = {7'd0, data_ready_r & measuring_s};
      6'h0E:   rd_data_s = measuring_s ? lo_byte(snap_x_r) : 8'h00;
      6'h0F:   rd_data_s = measuring_s ? hi_byte(snap_x_r) : 8'h00;
      6'h10:   rd_data_s = measuring_s ? lo_byte(snap_y_r) : 8'h00;
      6'h11:   rd_data_s = measuring_s ? hi_byte(snap_y_r) : 8'h00;
      6'h12:   rd_data_s = measuring_s ? lo_byte(snap_z_r) : 8'h00;
      6'h13:   rd_data_s = measuring_s ? hi_byte(snap_z_r) : 8'h00;
      6'h2D:   rd_data_s = power_ctl_r;
      default: rd_data_s = 8'h00;
    endcase
  end

  // Pin synchronizers. CSN resets low, so a select already active at reset
  // release never looks like a fall and that transaction is ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      csn_meta_r  <= 1'b0;
      csn_sync_r  <= 1'b0;
      csn_prev_r  <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      sclk_meta_r <= ACL_SCLK;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      csn_meta_r  <= ACL_CSN;
      csn_sync_r  <= csn_meta_r;
      csn_prev_r  <= csn_sync_r;
      mosi_meta_r <= ACL_MOSI;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  // Transaction FSM, receive shifter, byte counting and address pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 2'd0;
      rx_shift_r <= 8'h00;
      cmd_r      <= 8'h00;
      addr_r     <= 6'h00;
    end else if (csn_rise_s) begin
      state_r <= ST_IDLE;
    end else if (csn_fall_s) begin
      state_r    <= ST_CMD;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 2'd0;
      rx_shift_r <= 8'h00;
      cmd_r      <= 8'h00;
    end else if (sclk_rise_s && (state_r != ST_IDLE)) begin
      rx_shift_r <= rx_byte_s;
      bit_cnt_r  <= bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        if (byte_cnt_r != 2'd3) begin
          byte_cnt_r <= byte_cnt_r + 2'd1;
        end
        case (state_r)
          ST_CMD: begin
            cmd_r   <= rx_byte_s;
            state_r <= ST_ADDR;
          end
          ST_ADDR: begin
            addr_r  <= rx_byte_s[5:0];
            state_r <= ST_DATA;
          end
          ST_DATA: begin
            if (cmd_r == CMD_WRITE) begin
              addr_r <= addr_r + 6'd1;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end else if (tx_load_s) begin
      addr_r <= addr_r + 6'd1;
    end
  end

  // Read shifter: load on the first fall of each byte slot, then shift MSB first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      miso_r     <= 1'b0;
      tx_shift_r <= 7'd0;
      tx_cnt_r   <= 3'd0;
    end else if (csn_rise_s || csn_fall_s) begin
      miso_r     <= 1'b0;
      tx_shift_r <= 7'd0;
      tx_cnt_r   <= 3'd0;
    end else if ((state_r == ST_DATA) && (cmd_r == CMD_READ)) begin
      if (sclk_fall_s) begin
        tx_cnt_r <= tx_cnt_r + 3'd1;
        if (tx_cnt_r == 3'd0) begin
          miso_r     <= rd_data_s[7];
          tx_shift_r <= rd_data_s[6:0];
        end else begin
          miso_r     <= tx_shift_r[6];
          tx_shift_r <= {tx_shift_r[5:0], 1'b0};
        end
      end
    end else begin
      miso_r     <= 1'b0;
      tx_shift_r <= 7'd0;
      tx_cnt_r   <= 3'd0;
    end
  end

  // A measurement byte counts as read once all 8 of its bits were clocked out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_meas_r  <= 1'b0;
      meas_read_r <= 1'b0;
    end else if (csn_fall_s) begin
      cur_meas_r  <= 1'b0;
      meas_read_r <= 1'b0;
    end else begin
      if (tx_load_s) begin
        cur_meas_r <= is_meas_addr_s;
      end
      if (data_byte_end_s && (cmd_r == CMD_READ) && cur_meas_r) begin
        meas_read_r <= 1'b1;
      end
    end
  end

  // POWER_CTL is written only by a fully received data byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      power_ctl_r <= 8'h00;
    end else if (wr_commit_s) begin
      power_ctl_r <= rx_byte_s;
    end
  end

  // Holding register tracks the strobe; snapshot is frozen for a whole burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_x_r <= 12'd0;
      hold_y_r <= 12'd0;
      hold_z_r <= 12'd0;
      snap_x_r <= 12'd0;
      snap_y_r <= 12'd0;
      snap_z_r <= 12'd0;
    end else begin
      if (i_sample_valid) begin
        hold_x_r <= i_accel_x;
        hold_y_r <= i_accel_y;
        hold_z_r <= i_accel_z;
      end
      if (csn_fall_s) begin
        snap_x_r <= i_sample_valid ? i_accel_x : hold_x_r;
        snap_y_r <= i_sample_valid ? i_accel_y : hold_y_r;
        snap_z_r <= i_sample_valid ? i_accel_z : hold_z_r;
      end
    end
  end

  // DATA_READY: a new sample wins over the end-of-read clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_ready_r <= 1'b0;
    end else if (i_sample_valid && measuring_s) begin
      data_ready_r <= 1'b1;
    end else if (csn_rise_s && (state_r != ST_IDLE) && meas_read_r) begin
      data_ready_r <= 1'b0;
    end
  end

  // Busy flag and end-of-transaction pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r     <= 1'b0;
      txn_done_r <= 1'b0;
    end else begin
      txn_done_r <= csn_rise_s && (state_r != ST_IDLE) && (byte_cnt_r != 2'd0);
      if (csn_rise_s) begin
        busy_r <= 1'b0;
      end else if (csn_fall_s) begin
        busy_r <= 1'b1;
      end
    end
  end

  assign ACL_MISO    = miso_r;
  assign o_power_ctl = power_ctl_r;
  assign o_busy      = busy_r;
  assign o_txn_done  = txn_done_r;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Bench for spi_accel_responder: a bit-banged SPI master, directed scenarios,
// then random operations checked against a register-map model.
module tb_spi_accel_responder;
  localparam int HALF = 10;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        ACL_SCLK = 1'b0;
  logic        ACL_CSN = 1'b1;
  logic        ACL_MOSI = 1'b0;
  logic [11:0] i_accel_x = 12'd0;
  logic [11:0] i_accel_y = 12'd0;
  logic [11:0] i_accel_z = 12'd0;
  logic        i_sample_valid = 1'b0;
  logic        ACL_MISO;
  logic [7:0]  o_power_ctl;
  logic        o_busy;
  logic        o_txn_done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  logic [7:0] pwr_m;
  logic       dr_m;
  int         hold_m[3];
  int         snap_m[3];
  int         strobe_v[3];

  spi_accel_responder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .ACL_SCLK(ACL_SCLK), .ACL_CSN(ACL_CSN),
    .ACL_MOSI(ACL_MOSI), .i_accel_x(i_accel_x), .i_accel_y(i_accel_y),
    .i_accel_z(i_accel_z), .i_sample_valid(i_sample_valid), .ACL_MISO(ACL_MISO),
    .o_power_ctl(o_power_ctl), .o_busy(o_busy), .o_txn_done(o_txn_done)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_txn_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx12(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  // Register map as seen by the master, from the model state.
  function automatic logic [7:0] model_reg(input int a);
    int v;
    logic measuring;
    measuring = (pwr_m[1:0] == 2'b10);
    a = a % 64;
    if (a == 0) return 8'hAD;
    if (a == 1) return 8'h1D;
    if (a == 2) return 8'hF2;
    if (a == 11) return {7'd0, dr_m & measuring};
    if (a == 45) return pwr_m;
    if (a >= 14 && a <= 19) begin
      if (!measuring) return 8'h00;
      v = snap_m[(a - 14) / 2];
      if ((a - 14) % 2 == 0) return 8'(v & 255);
      return 8'((v >>> 8) & 255);
    end
    return 8'h00;
  endfunction

  task automatic model_reset();
    pwr_m = 8'h00;
    dr_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hold_m[k] = 0;
      snap_m[k] = 0;
    end
  endtask

  task automatic drive_sample(input int x, input int y, input int z);
    i_accel_x = 12'(x);
    i_accel_y = 12'(y);
    i_accel_z = 12'(z);
    i_sample_valid = 1'b1;
    hold_m[0] = x; hold_m[1] = y; hold_m[2] = z;
    if (pwr_m[1:0] == 2'b10) dr_m = 1'b1;
    @(negedge i_clk);
    i_sample_valid = 1'b0;
    i_accel_x = 12'($urandom);
    i_accel_y = 12'($urandom);
    i_accel_z = 12'($urandom);
  endtask

  // One CSN-low transaction of nbits bits from tx_q; received bytes go to rx_q.
  task automatic spi_txn(input int nbits, input int strobe_bit, input int reset_bit,
                         output int pulses);
    int d0;
    logic [7:0] cur;
    logic [7:0] b;
    d0 = done_cnt;
    rx_q.delete();
    cur = 8'h00;
    for (int k = 0; k < 3; k++) snap_m[k] = hold_m[k];
    @(negedge i_clk);
    ACL_CSN = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = tx_q[i / 8];
      ACL_MOSI = b[7 - (i % 8)];
      repeat (HALF) @(negedge i_clk);
      cur = {cur[6:0], ACL_MISO};
      if (i == 0) check("busy_mid", 32'(o_busy), 32'd1);
      if (i == reset_bit) begin
        i_rst_n = 1'b0;
        #1;
        check("rst_miso", 32'(ACL_MISO), 32'd0);
        check("rst_power", 32'(o_power_ctl), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
      end
      ACL_SCLK = 1'b1;
      repeat (HALF) @(negedge i_clk);
      ACL_SCLK = 1'b0;
      if (i % 8 == 7) rx_q.push_back(cur);
      if (i == strobe_bit) begin
        @(negedge i_clk);
        drive_sample(strobe_v[0], strobe_v[1], strobe_v[2]);
      end
    end
    repeat (HALF) @(negedge i_clk);
    ACL_CSN = 1'b1;
    repeat (8) @(negedge i_clk);
    pulses = done_cnt - d0;
    check("busy_end", 32'(o_busy), 32'd0);
    repeat (HALF) @(negedge i_clk);
  endtask

  task automatic do_read(input int start, input int n, input int strobe_bit, input string tag);
    logic [7:0] exp_q[$];
    int pulses;
    int a;
    logic touched;
    touched = 1'b0;
    for (int k = 0; k < 3; k++) snap_m[k] = hold_m[k];
    tx_q = '{8'h0B, 8'(start)};
    for (int k = 0; k < n; k++) begin
      a = (start + k) % 64;
      exp_q.push_back(model_reg(a));
      if (a >= 14 && a <= 19) touched = 1'b1;
      tx_q.push_back(8'($urandom));
    end
    spi_txn(8 * (n + 2), strobe_bit, -1, pulses);
    for (int k = 0; k < n; k++) check(tag, 32'(rx_q[k + 2]), 32'(exp_q[k]));
    check({tag, "_done"}, 32'(pulses), 32'd1);
    if (touched) dr_m = 1'b0;
  endtask

  task automatic do_write(input int start, input logic [7:0] d0, input logic [7:0] d1,
                          input int n, input int extra_bits, input string tag);
    int pulses;
    logic [7:0] dv[2];
    dv[0] = d0;
    dv[1] = d1;
    tx_q = '{8'h0A, 8'(start), d0, d1};
    spi_txn(16 + 8 * n + extra_bits, -1, -1, pulses);
    for (int k = 0; k < n; k++) if ((start + k) % 64 == 45) pwr_m = dv[k];
    check({tag, "_done"}, 32'(pulses), 32'd1);
    check({tag, "_pwr"}, 32'(o_power_ctl), 32'(pwr_m));
  endtask

  task automatic do_invalid(input logic [7:0] cmd);
    int pulses;
    tx_q = '{cmd, 8'($urandom), 8'($urandom), 8'($urandom)};
    spi_txn(32, -1, -1, pulses);
    check("inv_rx0", 32'(rx_q[2]), 32'd0);
    check("inv_rx1", 32'(rx_q[3]), 32'd0);
    check("inv_done", 32'(pulses), 32'd1);
    check("inv_pwr", 32'(o_power_ctl), 32'(pwr_m));
  endtask

  initial begin
    int p;
    int op;
    int st;
    logic [7:0] c;
    model_reset();
    repeat (3) @(negedge i_clk);
    check("reset_miso", 32'(ACL_MISO), 32'd0);
    check("reset_power", 32'(o_power_ctl), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_txn_done), 32'd0);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    check("idle_busy", 32'(o_busy), 32'd0);

    // ID registers with auto-increment
    tx_q = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};
    spi_txn(40, -1, -1, p);
    check("id_ad", 32'(rx_q[2]), 32'h0AD);
    check("id_1d", 32'(rx_q[3]), 32'h01D);
    check("id_f2", 32'(rx_q[4]), 32'h0F2);
    check("id_done", 32'(p), 32'd1);

    // POWER_CTL write and readback
    do_write(8'h2D, 8'h02, 8'h00, 1, 0, "wr_meas");
    check("pwr_lit", 32'(o_power_ctl), 32'h02);
    do_read(8'h2D, 1, -1, "rd_pwr");
    check("rd_pwr_lit", 32'(rx_q[2]), 32'h02);

    // Sign extension of measurement bytes, DATA_READY set/clear
    @(negedge i_clk);
    drive_sample(sx12(12'h800), sx12(12'h123), sx12(12'h7FF));
    do_read(8'h0B, 1, -1, "dr_set");
    check("dr_set_lit", 32'(rx_q[2]), 32'h01);
    do_read(8'h0E, 6, -1, "meas");
    check("meas_xl", 32'(rx_q[2]), 32'h00);
    check("meas_xh", 32'(rx_q[3]), 32'hF8);
    check("meas_yl", 32'(rx_q[4]), 32'h23);
    check("meas_yh", 32'(rx_q[5]), 32'h01);
    check("meas_zl", 32'(rx_q[6]), 32'hFF);
    check("meas_zh", 32'(rx_q[7]), 32'h07);
    do_read(8'h0B, 1, -1, "dr_clr");
    check("dr_clr_lit", 32'(rx_q[2]), 32'h00);

    // Sample strobed mid-burst must not tear the snapshot
    strobe_v[0] = sx12(12'h9AB); strobe_v[1] = sx12(12'h045); strobe_v[2] = sx12(12'hFFF);
    do_read(8'h0E, 6, 27, "tear");
    check("tear_xh", 32'(rx_q[3]), 32'hF8);
    check("tear_zh", 32'(rx_q[7]), 32'h07);
    do_read(8'h0E, 6, -1, "newsmp");
    check("new_xl", 32'(rx_q[2]), 32'hAB);
    check("new_xh", 32'(rx_q[3]), 32'hF9);
    check("new_yh", 32'(rx_q[5]), 32'h00);
    check("new_zh", 32'(rx_q[7]), 32'hFF);

    // Partial data byte is discarded; standby hides measurement data
    do_write(8'h2D, 8'h00, 8'h00, 0, 4, "partial");
    check("partial_lit", 32'(o_power_ctl), 32'h02);
    do_write(8'h2D, 8'h00, 8'h00, 1, 0, "standby");
    do_read(8'h0E, 1, -1, "stby_x");
    check("stby_lit", 32'(rx_q[2]), 32'h00);

    // Randomized operations against the model
    for (int it = 0; it < 16; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          st = ($urandom_range(0, 1) == 0) ? (45 + 64 * int'($urandom_range(0, 3)))
                                           : int'($urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) st = 44;
          do_write(st, ($urandom_range(0, 1) == 0) ? 8'h02 : 8'($urandom),
                   ($urandom_range(0, 1) == 0) ? 8'h0A : 8'($urandom),
                   int'($urandom_range(1, 2)), 0, "rnd_wr");
        end
        1: begin
          @(negedge i_clk);
          drive_sample(int'($urandom_range(0, 4095)) - 2048,
                       int'($urandom_range(0, 4095)) - 2048,
                       int'($urandom_range(0, 4095)) - 2048);
        end
        2: begin
          st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(11, 19))
                                           : int'($urandom_range(0, 255));
          do_read(st, int'($urandom_range(1, 4)), -1, "rnd_rd");
        end
        default: begin
          c = 8'($urandom);
          if (c == 8'h0A || c == 8'h0B) c = 8'h5C;
          do_invalid(c);
        end
      endcase
    end

    // Reset in the middle of a read; the aborted transaction stays ignored
    do_write(8'h2D, 8'h02, 8'h00, 1, 0, "pre_rst");
    tx_q = '{8'h0B, 8'h00, 8'h00, 8'h00};
    spi_txn(32, -1, 16, p);
    check("abort_b0", 32'(rx_q[2]), 32'h80);
    check("abort_b1", 32'(rx_q[3]), 32'h00);
    check("abort_done", 32'(p), 32'd0);
    check("abort_pwr", 32'(o_power_ctl), 32'h00);
    do_read(8'h01, 1, -1, "post_rst");
    check("post_rst_lit", 32'(rx_q[2]), 32'h1D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
